// File: rtl/servant_irq_pkg.sv
// Shared constants and helpers for the servant interrupt aggregator.
// Register word indices, COUNT width and an edge popcount.
package servant_irq_pkg;
  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_RAW     = 2'd2;
  localparam logic [1:0] REG_COUNT   = 2'd3;
  localparam int         COUNT_W     = 16;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/servant_irq_ctrl_if.sv
// Wishbone register-port bundle between the core and the irq aggregator.
interface servant_irq_ctrl_if;
  logic [1:0]  adr;
  logic [31:0] dat;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, we, cyc, input rdt, ack);
  modport slave  (input adr, dat, we, cyc, output rdt, ack);
endinterface

// File: rtl/servant_irq_sync.sv
// One irq source: SYNC_STAGES-deep synchroniser plus an edge-detect flop.
// o_rise is high for the single cycle after the synced level first goes high.
module servant_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_src,
  output logic o_level,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/servant_irq_ctrl.sv
// Interrupt aggregator: per-source sync, pending/enable/count registers,
// Wishbone register view and a single registered irq line to the core.
module servant_irq_ctrl
  import servant_irq_pkg::*;
#(
  parameter int          N_SRC       = 4,
  parameter logic [31:0] EDGE_MASK   = 32'hF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_SRC-1:0]   i_src,
  servant_irq_ctrl_if.slave  wb,
  output logic               o_irq
);
  localparam logic [N_SRC-1:0] EMASK = EDGE_MASK[N_SRC-1:0];

  logic [N_SRC-1:0]   w_level, w_rise, w_new, w_pend, w_clr;
  logic [N_SRC-1:0]   r_pend, r_en;
  logic [COUNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [COUNT_W:0]   w_sum;
  logic [31:0]        w_rd;
  logic               w_req, w_wr, w_unused_dat;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    servant_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_src   (i_src[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  // Level sources bypass the pending register and mirror the synced input.
  assign w_new  = w_rise & EMASK;
  assign w_pend = (r_pend & EMASK) | (w_level & ~EMASK);

  assign w_req = wb.cyc & ~wb.ack;
  assign w_wr  = w_req & wb.we;
  assign w_clr = (w_wr && wb.adr == REG_PENDING) ? (wb.dat[N_SRC-1:0] & EMASK) : '0;
  assign w_unused_dat = ^wb.dat;

  assign w_sum     = {1'b0, r_cnt} + (COUNT_W+1)'(popcount32(32'(w_new)));
  assign w_cnt_nxt = w_sum[COUNT_W] ? '1 : w_sum[COUNT_W-1:0];

  always_comb begin
    w_rd = '0;
    case (wb.adr)
      REG_PENDING: w_rd = 32'(w_pend);
      REG_ENABLE:  w_rd = 32'(r_en);
      REG_RAW:     w_rd = 32'(w_level);
      REG_COUNT:   w_rd = 32'(r_cnt);
      default:     w_rd = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      r_en   <= '0;
      r_cnt  <= '0;
      wb.ack <= 1'b0;
      wb.rdt <= '0;
      o_irq  <= 1'b0;
    end else begin
      // A new edge overrides a same-cycle W1C of that bit.
      r_pend <= ((r_pend & ~w_clr) | w_new) & EMASK;
      if (w_wr && wb.adr == REG_ENABLE) r_en <= wb.dat[N_SRC-1:0];
      if (w_wr && wb.adr == REG_COUNT) r_cnt <= '0;
      else                             r_cnt <= w_cnt_nxt;
      wb.ack <= w_req;
      wb.rdt <= w_req ? w_rd : '0;
      o_irq  <= |(w_pend & r_en);
    end
  end
endmodule

// File: tb/tb_servant_irq_ctrl.sv
// Directed bench: one all-edge instance and one with src0 as a level source.
module tb_servant_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  b_src0 = '0, b_src1 = '0;
  logic [1:0]  b_adr = '0;
  logic [31:0] b_dat = '0;
  logic        b_we = 1'b0, b_cyc = 1'b0, b_sel = 1'b0;
  logic        irq0, irq1, w_ack;
  logic [31:0] w_rdt, rd;
  int          total = 0, passed = 0;

  always #5 clk = ~clk;

  servant_irq_ctrl_if wb0 ();
  servant_irq_ctrl_if wb1 ();
  assign wb0.adr = b_adr;  assign wb0.dat = b_dat;  assign wb0.we = b_we;
  assign wb0.cyc = b_cyc & ~b_sel;
  assign wb1.adr = b_adr;  assign wb1.dat = b_dat;  assign wb1.we = b_we;
  assign wb1.cyc = b_cyc & b_sel;
  assign w_ack = b_sel ? wb1.ack : wb0.ack;
  assign w_rdt = b_sel ? wb1.rdt : wb0.rdt;

  servant_irq_ctrl #(.N_SRC(4), .EDGE_MASK(32'hF), .SYNC_STAGES(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_src(b_src0), .wb(wb0.slave), .o_irq(irq0));
  servant_irq_ctrl #(.N_SRC(4), .EDGE_MASK(32'hE), .SYNC_STAGES(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_src(b_src1), .wb(wb1.slave), .o_irq(irq1));

  task automatic xfer(input logic sel, input logic we, input logic [1:0] adr,
                      input logic [31:0] dat, output logic [31:0] rdt);
    logic got;
    got = 1'b0;
    @(negedge clk);
    b_sel = sel; b_we = we; b_adr = adr; b_dat = dat; b_cyc = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = w_ack;
    end
    rdt = w_rdt;
    b_cyc = 1'b0; b_we = 1'b0;
    if (!got) begin
      total++;
      $display("FAIL ack_timeout: no ack within 8 cycles (adr %0d)", adr);
    end
  endtask

  task automatic test_reset();
    b_src0 = 4'hF; b_src1 = 4'hF; rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (irq0 !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq0); else passed++;
    total++; if (wb0.ack !== 1'b0 || wb0.rdt !== 32'h0)
      $display("FAIL rst_wb: ack %b rdt %h want 0/0", wb0.ack, wb0.rdt); else passed++;
    b_src0 = '0; b_src1 = '0;
    @(negedge clk) rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      xfer(1'b0, 1'b0, 2'(a), 32'h0, rd);
      total++; if (rd !== 32'h0) $display("FAIL rst_reg%0d: got %h want 0", a, rd); else passed++;
    end
  endtask

  task automatic test_timer_edge();
    xfer(1'b0, 1'b1, 2'd1, 32'h1, rd);
    @(negedge clk) b_src0[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (irq0 !== 1'b0) $display("FAIL edge_irq_e3: got %b want 0", irq0); else passed++;
    @(posedge clk); #1;
    total++; if (irq0 !== 1'b1) $display("FAIL edge_irq_e4: got %b want 1", irq0); else passed++;
    xfer(1'b0, 1'b0, 2'd0, 32'h0, rd);
    total++; if (rd !== 32'h1) $display("FAIL edge_pend: got %h want 1", rd); else passed++;
    xfer(1'b0, 1'b1, 2'd0, 32'h1, rd);
    @(posedge clk); #1;
    total++; if (irq0 !== 1'b0) $display("FAIL edge_w1c_irq: got %b want 0", irq0); else passed++;
    xfer(1'b0, 1'b0, 2'd0, 32'h0, rd);
    total++; if (rd !== 32'h0) $display("FAIL edge_w1c_pend: got %h want 0", rd); else passed++;
    xfer(1'b0, 1'b0, 2'd3, 32'h0, rd);
    total++; if (rd !== 32'h1) $display("FAIL edge_count: got %h want 1", rd); else passed++;
  endtask

  task automatic test_masking();
    xfer(1'b0, 1'b1, 2'd1, 32'h0, rd);
    @(negedge clk) b_src0[2] = 1'b1;
    repeat (5) @(posedge clk);
    xfer(1'b0, 1'b0, 2'd0, 32'h0, rd);
    total++; if (rd !== 32'h4) $display("FAIL mask_pend: got %h want 4", rd); else passed++;
    total++; if (irq0 !== 1'b0) $display("FAIL mask_irq_off: got %b want 0", irq0); else passed++;
    xfer(1'b0, 1'b1, 2'd1, 32'h4, rd);
    total++; if (irq0 !== 1'b0) $display("FAIL mask_irq_ack: got %b want 0", irq0); else passed++;
    @(posedge clk); #1;
    total++; if (irq0 !== 1'b1) $display("FAIL mask_irq_on: got %b want 1", irq0); else passed++;
  endtask

  task automatic test_race();
    xfer(1'b0, 1'b1, 2'd3, 32'h0, rd);
    @(negedge clk) b_src0[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    b_sel = 1'b0; b_we = 1'b1; b_adr = 2'd0; b_dat = 32'h2; b_cyc = 1'b1;
    @(posedge clk); #1;
    total++; if (w_ack !== 1'b1) $display("FAIL race_ack: got %b want 1", w_ack); else passed++;
    b_cyc = 1'b0; b_we = 1'b0;
    xfer(1'b0, 1'b0, 2'd0, 32'h0, rd);
    total++; if (rd !== 32'h6) $display("FAIL race_pend: got %h want 6", rd); else passed++;
    xfer(1'b0, 1'b0, 2'd3, 32'h0, rd);
    total++; if (rd !== 32'h1) $display("FAIL race_count: got %h want 1", rd); else passed++;
  endtask

  task automatic test_level();
    xfer(1'b1, 1'b1, 2'd1, 32'h1, rd);
    @(negedge clk) b_src1[0] = 1'b1;
    repeat (4) @(posedge clk);
    xfer(1'b1, 1'b0, 2'd0, 32'h0, rd);
    total++; if (rd !== 32'h1) $display("FAIL lvl_pend_hi: got %h want 1", rd); else passed++;
    total++; if (irq1 !== 1'b1) $display("FAIL lvl_irq_hi: got %b want 1", irq1); else passed++;
    xfer(1'b1, 1'b1, 2'd0, 32'h1, rd);
    xfer(1'b1, 1'b0, 2'd0, 32'h0, rd);
    total++; if (rd !== 32'h1) $display("FAIL lvl_w1c: got %h want 1", rd); else passed++;
    @(negedge clk) b_src1[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (irq1 !== 1'b0) $display("FAIL lvl_irq_lo: got %b want 0", irq1); else passed++;
    xfer(1'b1, 1'b0, 2'd0, 32'h0, rd);
    total++; if (rd !== 32'h0) $display("FAIL lvl_pend_lo: got %h want 0", rd); else passed++;
    xfer(1'b1, 1'b0, 2'd3, 32'h0, rd);
    total++; if (rd !== 32'h0) $display("FAIL lvl_count: got %h want 0", rd); else passed++;
  endtask

  task automatic test_held_cyc();
    @(negedge clk);
    b_sel = 1'b0; b_we = 1'b0; b_adr = 2'd1; b_cyc = 1'b1;
    @(posedge clk); #1;
    total++; if (w_ack !== 1'b1 || w_rdt !== 32'h4)
      $display("FAIL held_first: ack %b rdt %h want 1/4", w_ack, w_rdt); else passed++;
    @(posedge clk); #1;
    total++; if (w_ack !== 1'b0 || w_rdt !== 32'h0)
      $display("FAIL held_second: ack %b rdt %h want 0/0", w_ack, w_rdt); else passed++;
    b_cyc = 1'b0;
  endtask

  task automatic test_count_sat();
    @(negedge clk) b_src0 = '0;
    repeat (4) @(posedge clk);
    xfer(1'b0, 1'b1, 2'd3, 32'h0, rd);
    for (int i = 0; i < 16383; i++) begin
      @(negedge clk) b_src0 = 4'hF;
      @(negedge clk);
      @(negedge clk) b_src0 = 4'h0;
      @(negedge clk);
    end
    repeat (4) @(posedge clk);
    xfer(1'b0, 1'b0, 2'd3, 32'h0, rd);
    total++; if (rd !== 32'hFFFC) $display("FAIL cnt_near: got %h want fffc", rd); else passed++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk) b_src0 = 4'hF;
      @(negedge clk);
      @(negedge clk) b_src0 = 4'h0;
      @(negedge clk);
    end
    repeat (4) @(posedge clk);
    xfer(1'b0, 1'b0, 2'd3, 32'h0, rd);
    total++; if (rd !== 32'hFFFF) $display("FAIL cnt_sat: got %h want ffff", rd); else passed++;
    xfer(1'b0, 1'b1, 2'd3, 32'h1234, rd);
    xfer(1'b0, 1'b0, 2'd3, 32'h0, rd);
    total++; if (rd !== 32'h0) $display("FAIL cnt_clear: got %h want 0", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_timer_edge();
    test_masking();
    test_race();
    test_level();
    test_held_cyc();
    test_count_sat();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
